// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display blocks.
// Segment codes are active-low {a,b,c,d,e,f,g,dp}. In these codes the decimal point
// bit is off, and the decoder adds the real dp value afterwards.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_0    = 8'b0000001_1;
    localparam logic [7:0] SEG_1    = 8'b1001111_1;
    localparam logic [7:0] SEG_2    = 8'b0010010_1;
    localparam logic [7:0] SEG_3    = 8'b0000110_1;
    localparam logic [7:0] SEG_4    = 8'b1001100_1;
    localparam logic [7:0] SEG_5    = 8'b0100100_1;
    localparam logic [7:0] SEG_6    = 8'b1100000_1;
    localparam logic [7:0] SEG_7    = 8'b0001101_1;
    localparam logic [7:0] SEG_8    = 8'b0000000_1;
    localparam logic [7:0] SEG_9    = 8'b0000100_1;
    localparam logic [7:0] SEG_DASH = 8'b1111110_1;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // One complete display value: four BCD nibbles and their decimal points.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
    } disp_word_t;

    // Active-low one-cold anode pattern for the digit being scanned.
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment decoder with decimal point and blanking.
// Nibbles 10..15 are shown as a dash. A blanked digit turns off every segment,
// and this includes the decimal point.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    // Look up the glyph and then apply the decimal point, unless the digit is blanked.
    always_comb begin
        // NOTE: the default is assigned first so that every path drives seg and no latch is inferred.
        seg = SEG_OFF;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
            seg[0] = ~dp;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller for the 4-digit common-anode seven-segment display.
// Each digit gets a slot of SCAN_DIV cycles. The first BLANK_CYC cycles of every slot
// are dark, which suppresses ghosting. An update is held in a pending buffer and
// moves to the displayed value only at a frame boundary, so a half-written number
// is never shown.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    input  logic        upd_valid,
    output logic        upd_ready,
    output logic        frame_start,
    output logic [3:0]  am,
    output logic [7:0]  out
);

    localparam int                CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       idx;
    disp_word_t       active;
    disp_word_t       pending;
    logic             pend_full;

    logic             slot_end;
    logic             frame_end;
    logic             accept;
    logic [3:0]       lz_blank;
    logic [3:0]       cur_digit;
    logic             cur_dp;
    logic [7:0]       cur_seg;

    assign slot_end  = (slot_cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);
    assign accept    = upd_valid && !pend_full;
    assign upd_ready = !pend_full;

    // Slot counter and digit index. The 2-bit index wraps from 3 back to 0 on its own.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so that all of them update together on the edge.
        if (!reset) begin
            slot_cnt <= '0;
            idx      <= 2'd0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Pending flag and the displayed value. A full buffer is moved to the display only at a frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_full <= 1'b0;
            active    <= '0;
        end else if (frame_end && pend_full) begin
            active    <= pending;
            pend_full <= 1'b0;
        end else if (accept) begin
            pend_full <= 1'b1;
        end
    end

    // Capture the pending data. The data is meaningful only while pend_full is set.
    always_ff @(posedge clk) begin
        // NOTE: this is a plain data register with no reset; pend_full is the only thing that marks it valid.
        if (accept) begin
            pending <= '{digits: digits_in, dp: dp_in};
        end
    end

    // Leading-zero suppression. A digit is blank when it and every digit to its left are zero. digit0 is never blanked.
    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = lz_en && (active.digits[15:12] == 4'd0);
        lz_blank[2] = lz_en && (active.digits[15:8]  == 8'd0);
        lz_blank[1] = lz_en && (active.digits[15:4]  == 12'd0);
    end

    assign cur_digit = active.digits[{idx, 2'b00} +: 4];
    assign cur_dp    = active.dp[idx];

    seg7_decode u_decode (
        .bcd   (cur_digit),
        .dp    (cur_dp),
        .blank (lz_blank[idx]),
        .seg   (cur_seg)
    );

    // Registered outputs. They show the counter state of the previous cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            am          <= ANODE_OFF;
            out         <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (slot_cnt == '0) && (idx == 2'd0);
            if (slot_cnt < CNT_BLANK) begin
                am  <= ANODE_OFF;
                out <= SEG_OFF;
            end else begin
                am  <= anode_sel(idx);
                out <= cur_seg;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with SCAN_DIV=8 and BLANK_CYC=2.
// The expected display is derived from elapsed cycles since reset with plain arithmetic.
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * SCAN_DIV;

    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b1100000, 7'b0001101,
        7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
        7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic        upd_valid;
    logic        upd_ready;
    logic        frame_start;
    logic [3:0]  am;
    logic [7:0]  out;

    int n_checks = 0;
    int n_fail   = 0;
    int cur      = 0;

    seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .lz_en       (lz_en),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .frame_start (frame_start),
        .am          (am),
        .out         (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model counts cycles since reset release. At cycle n the controller scans slot
    // position n % SCAN_DIV of digit (n / SCAN_DIV) % 4. The outputs show that position
    // one cycle later.
    function automatic logic [3:0] model_am(input int n);
        logic [3:0] one;
        one = 4'b0001;
        if ((n % SCAN_DIV) < BLANK_CYC) return 4'hF;
        return ~(one << ((n / SCAN_DIV) % 4));
    endfunction

    function automatic logic [7:0] model_out(input int n, input logic [15:0] d,
                                             input logic [3:0] dp, input logic lz);
        int di;
        logic [3:0] nib;
        di = (n / SCAN_DIV) % 4;
        if ((n % SCAN_DIV) < BLANK_CYC) return 8'hFF;
        if (lz && di != 0 && (d >> (4 * di)) == 16'h0) return 8'hFF;
        nib = d[4 * di +: 4];
        return {SEG_TAB[nib], ~dp[di]};
    endfunction

    int          m_n     = 0;
    logic        m_full  = 1'b0;
    logic [15:0] m_pd    = '0;
    logic [3:0]  m_pdp   = '0;
    logic [15:0] m_ad    = '0;
    logic [3:0]  m_adp   = '0;
    logic [3:0]  exp_am  = 4'hF;
    logic [7:0]  exp_out = 8'hFF;
    logic        exp_fs  = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_n     <= 0;
            m_full  <= 1'b0;
            m_ad    <= '0;
            m_adp   <= '0;
            exp_am  <= 4'hF;
            exp_out <= 8'hFF;
            exp_fs  <= 1'b0;
        end else begin
            exp_am  <= model_am(m_n);
            exp_out <= model_out(m_n, m_ad, m_adp, lz_en);
            exp_fs  <= (m_n % FRAME == 0);
            if ((m_n % FRAME == FRAME - 1) && m_full) begin
                m_ad   <= m_pd;
                m_adp  <= m_pdp;
                m_full <= 1'b0;
            end else if (upd_valid && !m_full) begin
                m_pd   <= digits_in;
                m_pdp  <= dp_in;
                m_full <= 1'b1;
            end
            m_n <= m_n + 1;
        end
    end

    // Compare the DUT with the model on every falling edge while out of reset.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("cmp_am", am, exp_am);
            check("cmp_out", out, exp_out);
            check("cmp_frame_start", frame_start, exp_fs);
            check("cmp_upd_ready", upd_ready, !m_full);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync_frame();
        bit found;
        found = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_sync: no frame_start within 80 cycles at %0t", $time);
        end
        cur = 0;
    endtask

    task automatic goto(input int off);
        while (cur < off) begin
            @(negedge clk);
            cur++;
        end
    endtask

    // Start an update a few cycles into a frame. It should be displayed from the next frame onward.
    task automatic send_mid(input logic [15:0] d, input logic [3:0] p);
        sync_frame();
        goto(3);
        digits_in = d;
        dp_in     = p;
        upd_valid = 1'b1;
        goto(4);
        upd_valid = 1'b0;
        check("send_ready_low", upd_ready, 1'b0);
    endtask

    initial begin
        reset     = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        lz_en     = 1'b0;
        upd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_am", am, 4'hF);
        check("rst_out", out, 8'hFF);
        check("rst_ready", upd_ready, 1'b1);
        check("rst_frame_start", frame_start, 1'b0);
        reset = 1'b1;

        // Scan order after reset, with all digits showing 0.
        sync_frame();
        check("t1_am_blank0", am, 4'hF);
        goto(2);  check("t1_am_d0", am, 4'b1110); check("t1_out_d0", out, 8'h03);
        goto(7);  check("t1_am_d0_end", am, 4'b1110);
        goto(8);  check("t1_am_blank1", am, 4'hF); check("t1_out_blank1", out, 8'hFF);
        goto(10); check("t1_am_d1", am, 4'b1101);
        goto(18); check("t1_am_d2", am, 4'b1011);
        goto(26); check("t1_am_d3", am, 4'b0111);

        // The update is accepted mid-frame, and the old value stays visible until the boundary.
        send_mid(16'h1234, 4'b0010);
        goto(10); check("t2_old_d1", out, 8'h03);
        sync_frame();
        goto(2);  check("t2_d0", out, 8'h99);
        goto(10); check("t2_d1", out, 8'h0C);
        goto(18); check("t2_d2", out, 8'h25);
        goto(26); check("t2_d3", out, 8'h9F); check("t2_ready", upd_ready, 1'b1);

        // Leading-zero suppression.
        lz_en = 1'b1;
        send_mid(16'h0005, 4'b0000);
        sync_frame();
        goto(2);  check("t3_d0", out, 8'h49);
        goto(10); check("t3_d1_blank", out, 8'hFF); check("t3_d1_am", am, 4'b1101);
        goto(18); check("t3_d2_blank", out, 8'hFF);
        goto(26); check("t3_d3_blank", out, 8'hFF); check("t3_d3_am", am, 4'b0111);
        send_mid(16'h0000, 4'b1111);
        sync_frame();
        goto(2);  check("t3_zero_d0", out, 8'h02);
        goto(10); check("t3_zero_d1", out, 8'hFF);

        // A non-BCD nibble is shown as a dash.
        send_mid(16'h0B00, 4'b0000);
        sync_frame();
        goto(10); check("t4_d1", out, 8'h03);
        goto(18); check("t4_d2_dash", out, 8'hFD);
        goto(26); check("t4_d3_blank", out, 8'hFF);
        lz_en = 1'b0;

        // A second request is held off while an update is pending.
        sync_frame();
        goto(3);
        digits_in = 16'h5678; dp_in = 4'b0000; upd_valid = 1'b1;
        goto(4);
        digits_in = 16'h4321; dp_in = 4'b1000;
        check("t5_ready_low", upd_ready, 1'b0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (upd_ready === 1'b1) break;
        end
        @(negedge clk);
        upd_valid = 1'b0;
        cur = 0;
        check("t5_frame_a", frame_start, 1'b1);
        goto(2);  check("t5_a_d0", out, 8'h01);
        sync_frame();
        goto(2);  check("t5_b_d0", out, 8'h9F);
        goto(26); check("t5_b_d3", out, 8'h98);
        goto(30);
        digits_in = 16'h0009; dp_in = 4'b0000; upd_valid = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        check("t5_bnd_ready", upd_ready, 1'b0);
        sync_frame();
        goto(2);  check("t5_bnd_still_b", out, 8'h9F);
        sync_frame();
        goto(2);  check("t5_bnd_applied", out, 8'h09);

        // Reset in the digit2 slot while an update is pending.
        send_mid(16'h8888, 4'b1111);
        goto(20);
        #2 reset = 1'b0;
        #1;
        check("t6_am_async", am, 4'hF);
        check("t6_out_async", out, 8'hFF);
        check("t6_ready", upd_ready, 1'b1);
        check("t6_frame_start", frame_start, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        sync_frame();
        goto(2);  check("t6_d0", out, 8'h03); check("t6_am", am, 4'b1110);
        goto(34); check("t6_no_pending", out, 8'h03);

        // Random traffic checked against the model.
        for (int i = 0; i < 800; i++) begin
            logic [15:0] mask;
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h0FFF;
                2:       mask = 16'h00FF;
                default: mask = 16'h000F;
            endcase
            upd_valid = ($urandom_range(0, 3) == 0);
            digits_in = 16'($urandom) & mask;
            dp_in     = 4'($urandom);
            if ($urandom_range(0, 7) == 0) lz_en = ~lz_en;
        end
        upd_valid = 1'b0;
        repeat (80) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
